// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the async FIFO and the UART transmitter.
// The transmitter owns the read-increment pulse; the FIFO owns flag and data.
interface fifo_uart_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  i_empty;
   logic [DATA_WIDTH-1:0] i_rd_data;
   logic                  o_r_inc;

   modport master (
      input  i_empty,
      input  i_rd_data,
      output o_r_inc
   );

   modport slave (
      output i_empty,
      output i_rd_data,
      input  o_r_inc
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining the read side of the async FIFO.
// One byte popped per frame: start, data LSB first, optional parity, stop.
module fifo_uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_DIV   = 16
) (
   input  logic           i_clk,
   input  logic           i_rst,
   fifo_uart_tx_if.master bus,
   input  logic           i_tx_en,
   input  logic           i_par_en,
   input  logic           i_par_typ,
   output logic           o_tx,
   output logic           o_busy
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state;
   state_t                state_d;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_d;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         idx_d;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  pop;
   logic                  bit_end;
   logic                  tx_d;

   assign bit_end     = (cnt == CNT_LAST);
   assign bus.o_r_inc = pop;

   // Next-state, baud/bit counters and the combinational pop pulse
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = idx;
      pop     = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (i_tx_en && !bus.i_empty && !i_rst) begin
               pop     = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (idx == IDX_LAST) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  idx_d = idx + 1'b1;
               end
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = STOP;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Line level for the upcoming cycle, so o_tx can be a plain register
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg[idx_d];
         PARITY:  tx_d = (^shreg) ^ par_typ_q;
         default: tx_d = 1'b1;
      endcase
   end

   // State, counters and registered line/busy outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state  <= IDLE;
         cnt    <= '0;
         idx    <= '0;
         o_tx   <= 1'b1;
         o_busy <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         idx    <= idx_d;
         o_tx   <= tx_d;
         o_busy <= (state_d != IDLE);
      end
   end

   // Capture the popped byte and its framing options for the whole frame
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         shreg     <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
      end else if (pop) begin
         shreg     <= bus.i_rd_data;
         par_en_q  <= i_par_en;
         par_typ_q <= i_par_typ;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model on the read port, line decoder,
// and expected-frame scoreboard checked scenario by scenario.
module tb_fifo_uart_tx;

   localparam int DW = 8;
   localparam int BD = 4;

   typedef struct {
      logic [7:0] data;
      bit         par_en;
      bit         par_typ;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      int         len;
      logic       start_bit;
      logic       par_bit;
      logic       stop_bit;
      bit         stable;
      int         start_cyc;
   } rx_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx_en = 1'b0;
   logic par_en = 1'b0;
   logic par_typ = 1'b0;
   logic tx;
   logic busy;

   exp_t       exp_q[$];
   rx_t        rx_q[$];
   logic [7:0] fifo_q[$];
   int         pop_cyc_q[$];
   int         cyc = 0;
   int         pops = 0;
   int         n_cmp = 0;
   int         n_bad = 0;

   fifo_uart_tx_if #(.DATA_WIDTH(DW)) bus ();

   fifo_uart_tx #(
      .DATA_WIDTH(DW),
      .BAUD_DIV  (BD)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .bus      (bus),
      .i_tx_en  (tx_en),
      .i_par_en (par_en),
      .i_par_typ(par_typ),
      .o_tx     (tx),
      .o_busy   (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: pop sampled mid-cycle, applied just after the edge
   initial begin
      bit pend;
      int pcyc;
      bus.i_empty   = 1'b1;
      bus.i_rd_data = '0;
      forever begin
         @(negedge clk);
         pend = bus.o_r_inc;
         pcyc = cyc;
         @(posedge clk);
         #2;
         if (pend) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pops++;
            pop_cyc_q.push_back(pcyc);
         end
         bus.i_empty   = (fifo_q.size() == 0);
         bus.i_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
      end
   end

   // Line decoder: one record per busy window
   initial begin
      logic s[$];
      bit   inf;
      int   sc;
      rx_t  r;
      inf = 0;
      sc  = 0;
      forever begin
         @(negedge clk);
         if (busy === 1'b1) begin
            if (!inf) begin
               inf = 1;
               sc  = cyc;
            end
            s.push_back(tx);
         end else if (inf) begin
            r.len       = s.size();
            r.start_cyc = sc;
            r.start_bit = s[0];
            r.data      = '0;
            for (int k = 0; k < DW; k++)
               if ((k + 1) * BD < s.size()) r.data[k] = s[(k + 1) * BD];
            r.par_bit  = (s.size() >= (DW + 3) * BD) ? s[(DW + 1) * BD] : 1'b0;
            r.stop_bit = s[s.size() - 1];
            r.stable   = 1;
            for (int i = 0; i < s.size(); i++)
               if (s[i] !== s[(i / BD) * BD]) r.stable = 0;
            rx_q.push_back(r);
            inf = 0;
            s.delete();
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1);
   end

   function automatic logic [11:0] exp_sig(exp_t e);
      logic p;
      p = e.par_en ? ((^e.data) ^ e.par_typ) : 1'b0;
      return {1'b0, e.data, p, 1'b1, 1'b1};
   endfunction

   function automatic logic [11:0] rx_sig(rx_t r);
      return {r.start_bit, r.data, r.par_bit, r.stop_bit, r.stable};
   endfunction

   function automatic int exp_len(exp_t e);
      return (DW + 2 + (e.par_en ? 1 : 0)) * BD;
   endfunction

   task automatic push(input logic [7:0] d);
      fifo_q.push_back(d);
      exp_q.push_back('{d, par_en, par_typ});
   endtask

   task automatic get_frame(output rx_t r, output bit ok);
      ok = 0;
      r  = '{default: 0};
      for (int i = 0; i < 400; i++) begin
         if (rx_q.size() > 0) break;
         @(negedge clk);
      end
      if (rx_q.size() > 0) begin
         r  = rx_q.pop_front();
         ok = 1;
      end
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      tx_en = 1'b1;
      fifo_q.push_back(8'hEE);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({tx, busy, bus.o_r_inc} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 100", {tx, busy, bus.o_r_inc});
         end
      end
      @(posedge clk); #1;
      fifo_q.delete();
      tx_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({tx, busy, pops} !== {2'b10, 32'd0}) begin
         n_bad++;
         $display("FAIL reset_idle: got tx=%b busy=%b pops=%0d want 1 0 0", tx, busy, pops);
      end
   endtask

   task automatic test_basic();
      rx_t  r;
      exp_t e;
      bit   ok;
      int   p0;
      pop_cyc_q.delete();
      @(posedge clk); #1;
      p0     = pops;
      par_en = 1'b0;
      tx_en  = 1'b1;
      push(8'hA5);
      get_frame(r, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL basic_timeout: got no frame want frame");
      end else begin
         n_cmp++;
         if (r.len !== exp_len(e)) begin
            n_bad++;
            $display("FAIL basic_len: got %0d want %0d", r.len, exp_len(e));
         end
         n_cmp++;
         if (rx_sig(r) !== exp_sig(e)) begin
            n_bad++;
            $display("FAIL basic_frame: got %h want %h", rx_sig(r), exp_sig(e));
         end
         n_cmp++;
         if (pop_cyc_q.size() != 1 || r.start_cyc !== pop_cyc_q[0] + 1) begin
            n_bad++;
            $display("FAIL basic_start: got cyc %0d want pop+1, pops seen %0d", r.start_cyc, pop_cyc_q.size());
         end
      end
      n_cmp++;
      if (pops - p0 !== 1) begin
         n_bad++;
         $display("FAIL basic_pops: got %0d want 1", pops - p0);
      end
   endtask

   task automatic test_parity();
      rx_t        r;
      exp_t       e;
      bit         ok;
      logic [7:0] bytes[3];
      logic       typs[3];
      bytes = '{8'hA5, 8'hA5, 8'h07};
      typs  = '{1'b0, 1'b1, 1'b0};
      for (int t = 0; t < 3; t++) begin
         @(posedge clk); #1;
         par_en  = 1'b1;
         par_typ = typs[t];
         tx_en   = 1'b1;
         push(bytes[t]);
         if (t == 1) begin
            repeat (12) @(posedge clk);
            #1 par_typ = ~par_typ;
            repeat (14) @(posedge clk);
            #1 par_typ = ~par_typ;
            #1 par_typ = ~par_typ;
         end
         get_frame(r, ok);
         e = exp_q.pop_front();
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL parity_timeout[%0d]: got no frame want frame", t);
         end else begin
            n_cmp++;
            if (r.len !== exp_len(e)) begin
               n_bad++;
               $display("FAIL parity_len[%0d]: got %0d want %0d", t, r.len, exp_len(e));
            end
            n_cmp++;
            if (rx_sig(r) !== exp_sig(e)) begin
               n_bad++;
               $display("FAIL parity_frame[%0d]: got %h want %h", t, rx_sig(r), exp_sig(e));
            end
         end
      end
      @(posedge clk); #1;
      par_en  = 1'b0;
      par_typ = 1'b0;
   endtask

   task automatic test_back_to_back();
      rx_t  r[2];
      exp_t e;
      bit   ok;
      int   p0;
      @(posedge clk); #1;
      p0    = pops;
      tx_en = 1'b1;
      push(8'h01);
      push(8'h80);
      for (int f = 0; f < 2; f++) begin
         get_frame(r[f], ok);
         e = exp_q.pop_front();
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL b2b_timeout[%0d]: got no frame want frame", f);
         end else begin
            n_cmp++;
            if (rx_sig(r[f]) !== exp_sig(e) || r[f].len !== exp_len(e)) begin
               n_bad++;
               $display("FAIL b2b_frame[%0d]: got %h/%0d want %h/%0d", f, rx_sig(r[f]), r[f].len, exp_sig(e), exp_len(e));
            end
         end
      end
      n_cmp++;
      if (r[1].start_cyc - r[0].start_cyc !== (DW + 2) * BD + 1) begin
         n_bad++;
         $display("FAIL b2b_spacing: got %0d want %0d", r[1].start_cyc - r[0].start_cyc, (DW + 2) * BD + 1);
      end
      repeat (60) @(negedge clk);
      n_cmp++;
      if (pops - p0 !== 2 || rx_q.size() != 0) begin
         n_bad++;
         $display("FAIL b2b_pops: got %0d pops %0d extra frames want 2 0", pops - p0, rx_q.size());
      end
   endtask

   task automatic test_enable_gating();
      rx_t  r;
      exp_t e;
      bit   ok;
      int   p0;
      int   en_cyc;
      @(posedge clk); #1;
      p0    = pops;
      tx_en = 1'b1;
      push(8'h3C);
      push(8'hC3);
      repeat (12) @(posedge clk);
      #1 tx_en = 1'b0;
      get_frame(r, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || rx_sig(r) !== exp_sig(e) || r.len !== exp_len(e)) begin
         n_bad++;
         $display("FAIL gate_first: got %h/%0d want %h/%0d", rx_sig(r), r.len, exp_sig(e), exp_len(e));
      end
      repeat (10) @(negedge clk);
      n_cmp++;
      if (pops - p0 !== 1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL gate_hold: got pops=%0d busy=%b want 1 0", pops - p0, busy);
      end
      @(posedge clk); #1;
      tx_en  = 1'b1;
      en_cyc = cyc;
      get_frame(r, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || rx_sig(r) !== exp_sig(e) || r.len !== exp_len(e)) begin
         n_bad++;
         $display("FAIL gate_second: got %h/%0d want %h/%0d", rx_sig(r), r.len, exp_sig(e), exp_len(e));
      end
      n_cmp++;
      if (r.start_cyc !== en_cyc + 1) begin
         n_bad++;
         $display("FAIL gate_resume: got cyc %0d want %0d", r.start_cyc, en_cyc + 1);
      end
   endtask

   task automatic test_reset_mid();
      rx_t  r;
      exp_t e;
      bit   ok;
      int   p0;
      int   rel;
      @(posedge clk); #1;
      p0    = pops;
      tx_en = 1'b1;
      push(8'h52);
      push(8'h96);
      repeat (18) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      n_cmp++;
      if ({tx, busy, bus.o_r_inc} !== 3'b100) begin
         n_bad++;
         $display("FAIL rstmid_immediate: got %b want 100", {tx, busy, bus.o_r_inc});
      end
      @(negedge clk);
      n_cmp++;
      if (bus.o_r_inc !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_nopop: got %b want 0", bus.o_r_inc);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      rel = cyc;
      get_frame(r, ok);
      void'(exp_q.pop_front());
      n_cmp++;
      if (!ok || r.len !== 1 + 4 * BD) begin
         n_bad++;
         $display("FAIL rstmid_trunc: got %0d cycles want %0d", r.len, 1 + 4 * BD);
      end
      get_frame(r, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok || rx_sig(r) !== exp_sig(e) || r.len !== exp_len(e)) begin
         n_bad++;
         $display("FAIL rstmid_next: got %h/%0d want %h/%0d", rx_sig(r), r.len, exp_sig(e), exp_len(e));
      end
      n_cmp++;
      if (r.start_cyc !== rel + 1) begin
         n_bad++;
         $display("FAIL rstmid_first_pop: got cyc %0d want %0d", r.start_cyc, rel + 1);
      end
      repeat (60) @(negedge clk);
      n_cmp++;
      if (pops - p0 !== 2 || rx_q.size() != 0) begin
         n_bad++;
         $display("FAIL rstmid_resend: got %0d pops %0d extra frames want 2 0", pops - p0, rx_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_back_to_back();
      test_enable_gating();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
